// File: rtl/rv_pkg.sv
// Shared RV32I core types: next-PC select encoding, fetch FSM states and
// the canonical NOP. The control unit's PCSrc output uses pc_src_t.
package rv_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC target mux with alignment handling.
// FETCH_MISALIGN_TRAP_EN defined: the raw target is passed through and a
// misaligned flag is exported. Undefined: the target is forced word-aligned.
module next_pc_gen
  import rv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;

  // Select the raw target; the reserved encoding falls back to sequential flow.
  always_comb begin
    target = pc_plus4;
    case (pc_src_t'(pc_src))
      PC_BRANCH: target = pc + imm_ext;
      PC_JALR:   target = alu_result & ~32'h1;
      default:   target = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc    = target;
  assign misaligned = |target[1:0];
`else
  assign next_pc    = target & ~32'h3;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack handshake and a held
// instruction register presented to execute with a valid/ready handshake.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky fault on a
// misaligned next-PC target instead of silently aligning it).
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fetch_fault
);

  fetch_state_t state;
  logic [31:0]  next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic fault_q;
`endif

  next_pc_gen u_next_pc_gen (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Fetch FSM with registered handshake outputs, PC and instruction register.
  // NOTE: all state here uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it overrides any ack seen on the same edge.
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
`else
            imem_req <= 1'b1;
            state    <= FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory responder
// (configurable ack latency) and hand-computed expectations.
module tb_fetch_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        fetch_fault;

  int n_vec    = 0;
  int n_miss   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit mem_en    = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .fetch_fault (fetch_fault)
  );

  // Memory content: recognisable word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ack after ack_delay cycles of continuous request.
  task automatic mem_drive();
    if (imem_req) begin
      imem_ack   = (wait_cnt == ack_delay);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      wait_cnt++;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_en) mem_drive();
  endtask

  task automatic accept(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    pc_src      = src;
    imm_ext     = imm;
    alu_result  = alu;
    instr_ready = 1'b1;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_src      = 2'b00;
    imm_ext     = 32'h0;
    alu_result  = 32'h0;

    // Reset state
    repeat (3) step();
    check("rst_req",   imem_req,    32'h0);
    check("rst_pc",    pc,          32'h0);
    check("rst_addr",  imem_addr,   32'h0);
    check("rst_instr", instr,       32'h0000_0013);
    check("rst_valid", instr_valid, 32'h0);
    check("rst_fault", fetch_fault, 32'h0);
    check("rst_plus4", pc_plus4,    32'h4);

    // Cycle 0 is IDLE; zero-wait sequential fetch 0x0, 0x4, 0x8
    rst = 1'b0;
    check("idle_req", imem_req, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq_req",  imem_req,  32'h1);
      check("seq_addr", imem_addr, 32'(i * 4));
      check("seq_valid_lo", instr_valid, 32'h0);
      step();
      check("seq_valid", instr_valid, 32'h1);
      check("seq_instr", instr, mem_word(32'(i * 4)));
      check("seq_req_lo", imem_req, 32'h0);
    end

    // Walk to pc=0x10, then stall in HOLD with control inputs toggling
    step();
    step();
    step();
    instr_ready = 1'b0;
    step();
    check("pre_hold_pc", pc, 32'h10);
    check("pre_hold_instr", instr, mem_word(32'h10));
    for (int i = 0; i < 5; i++) begin
      pc_src     = (i % 2 == 1) ? 2'b01 : 2'b10;
      imm_ext    = 32'h100 * i;
      alu_result = 32'h40 + 32'(i);
      step();
      check("hold_instr", instr,       mem_word(32'h10));
      check("hold_pc",    pc,          32'h10);
      check("hold_req",   imem_req,    32'h0);
      check("hold_valid", instr_valid, 32'h1);
    end

    // Backward branch: 0x10 + 0xFFFF_FFF8 = 0x08
    accept(2'b01, 32'hFFFF_FFF8, 32'h0);
    check("br_pc",   pc,        32'h8);
    check("br_addr", imem_addr, 32'h8);
    check("br_req",  imem_req,  32'h1);
    step();
    check("br_instr", instr, mem_word(32'h8));

    // Memory ack delayed 3 cycles: request held 4 cycles
    ack_delay = 3;
    accept(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("dly_req",   imem_req,    32'h1);
      check("dly_addr",  imem_addr,   32'hC);
      check("dly_valid", instr_valid, 32'h0);
      step();
    end
    check("dly_valid_hi", instr_valid, 32'h1);
    check("dly_instr",    instr,       mem_word(32'hC));
    ack_delay = 0;

    // jalr: 0x101 & ~1 = 0x100
    accept(2'b10, 32'h0, 32'h0000_0101);
    check("jalr_pc",    pc,        32'h100);
    check("jalr_addr",  imem_addr, 32'h100);
    check("jalr_plus4", pc_plus4,  32'h104);
    check("jalr_fault", fetch_fault, 32'h0);
    step();
    check("jalr_instr", instr, mem_word(32'h100));

    // Reserved select behaves as pc+4
    accept(2'b11, 32'h40, 32'h80);
    check("rsv_pc", pc, 32'h104);
    step();

    // Wrap-around at the top of the address space
    accept(2'b10, 32'h0, 32'hFFFF_FFFD);
    check("wrap_pc",    pc,       32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    step();
    check("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
    accept(2'b00, 32'h0, 32'h0);
    check("wrap_next_pc", pc, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    step();

    // Misaligned branch target 0x0 + 6 = 0x6
    accept(2'b01, 32'h6, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pc",    pc,          32'h6);
    check("mis_fault", fetch_fault, 32'h1);
    check("mis_req",   imem_req,    32'h0);
    check("mis_valid", instr_valid, 32'h0);
    repeat (3) step();
    check("mis_fault_sticky", fetch_fault, 32'h1);
    check("mis_req_sticky",   imem_req,    32'h0);
`else
    check("mis_pc",    pc,          32'h4);
    check("mis_fault", fetch_fault, 32'h0);
    check("mis_req",   imem_req,    32'h1);
`endif

    // Bring the unit to FETCH at pc=0x4 from a clean reset
    rst = 1'b1;
    step();
    rst         = 1'b0;
    instr_ready = 1'b1;
    pc_src      = 2'b00;
    step();
    step();
    step();
    check("pre_rst_pc",  pc,       32'h4);
    check("pre_rst_req", imem_req, 32'h1);

    // Reset pulsed during FETCH with an ack on the same edge
    mem_en     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst        = 1'b1;
    step();
    check("mrst_instr", instr,       32'h0000_0013);
    check("mrst_valid", instr_valid, 32'h0);
    check("mrst_pc",    pc,          32'h0);
    check("mrst_req",   imem_req,    32'h0);
    check("mrst_fault", fetch_fault, 32'h0);

    // Stale ack through the IDLE cycle is dropped
    rst = 1'b0;
    step();
    check("stale_valid", instr_valid, 32'h0);
    check("stale_instr", instr,       32'h0000_0013);
    check("stale_req",   imem_req,    32'h1);
    mem_en   = 1'b1;
    wait_cnt = 0;
    mem_drive();
    step();
    check("post_rst_instr", instr,       mem_word(32'h0));
    check("post_rst_valid", instr_valid, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
